emu_csr_sequencer: RTL
======================

# emu_csr_sequencer

Hardware command sequencer that drives the emulator CSR slave (AXI4-Lite, 12-bit address, 32-bit data) on behalf of a simple host command port. It converts one high-level command into the exact CSR transaction sequence: run, halt, step, reset-start, checkpoint save/load via DMA, and cycle readout. It sits between the host or test controller and the `s_axilite_*` port of `emu_system`, replacing hand-written CSR polling loops.

## Interface
- `ADDR_STAT`, default `` `EMU_STAT ``: CSR address of the status/control register.
- `ADDR_STEP`, default `` `EMU_STEP ``: CSR address of the step count register.
- `ADDR_CYCLE_LO` / `ADDR_CYCLE_HI`, default `` `EMU_CYCLE_LO `` / `` `EMU_CYCLE_HI ``: CSR addresses of the cycle counter halves.
- `ADDR_DMA_LO` / `ADDR_DMA_HI` / `ADDR_DMA_CTRL` / `ADDR_DMA_STAT`, default `` `EMU_DMA_* ``: CSR addresses of the DMA registers.
- `POLL_GAP`, default 16: idle cycles between the end of one poll read and the next AR.
- `POLL_MAX`, default 1024: poll limit; used only under `EMU_SEQ_TIMEOUT_EN`.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `cmd_valid  in  1`, `cmd_ready  out  1`: command handshake.
- `cmd_op  in  3`: 0 RUN, 1 HALT, 2 STEP, 3 RESET_START, 4 SAVE, 5 LOAD, 6 READ_CYCLE, 7 illegal.
- `cmd_arg  in  32`: step count (STEP) or cycle_lo to restore (LOAD).
- `cmd_addr  in  64`: DMA base address (SAVE/LOAD).
- `rsp_valid  out  1`, `rsp_ready  in  1`: response handshake.
- `rsp_data  out  64`: `{cycle_hi, cycle_lo}` for SAVE and READ_CYCLE; 0 otherwise.
- `rsp_err  out  1`: command failed.
- `busy  out  1`: state is not IDLE.
- `m_arvalid/m_arready/m_araddr[11:0]`, `m_rvalid/m_rready/m_rdata[31:0]/m_rresp[1:0]`, `m_awvalid/m_awready/m_awaddr[11:0]`, `m_wvalid/m_wready/m_wdata[31:0]/m_wstrb[3:0]`, `m_bvalid/m_bready/m_bresp[1:0]`: AXI4-Lite master to the CSR slave.

## Operation
- **States**: IDLE, WRITE, WAIT_B, READ, WAIT_R, DELAY, RESP. A 4-bit step index selects the next micro-op within the command.
- **Micro-op sequences** (W = write, R = read):
  - RUN: W STAT=0.
  - HALT: W STAT=1.
  - STEP: W STEP=arg; W STAT=0.
  - RESET_START: W STAT=2; poll R STAT until bit0=1; W STAT=1.
  - SAVE: W STAT=1; W DMA_LO=addr[31:0]; W DMA_HI=addr[63:32]; W DMA_CTRL=1; poll R DMA_STAT until bit0=0; R CYCLE_LO; R CYCLE_HI.
  - LOAD: W STAT=1; W CYCLE_LO=arg; W DMA_LO; W DMA_HI; W DMA_CTRL=3; poll R DMA_STAT until bit0=0.
  - READ_CYCLE: R CYCLE_LO; R CYCLE_HI.
  - op 7: no bus activity; go straight to RESP with rsp_err=1.
- **WRITE**: assert awvalid and wvalid together, `wstrb=4'hF`. Each valid drops independently on its own handshake. Go to WAIT_B when both are done. `bready` is held at 1. A bresp≠0 jumps to RESP with err=1 (remaining micro-ops skipped).
- **READ**: assert arvalid until arready. `rready` is held at 1. rdata is captured on rvalid. An rresp≠0 aborts the same way as bresp.
- **Polling**: when the poll condition is unmet, DELAY for POLL_GAP cycles, then re-issue the read. When met, advance to the next micro-op.
- **RESP**: `rsp_valid` is held with stable data until `rsp_ready`, then return to IDLE.

## Timing
- **Reset values**: state IDLE; `cmd_ready=1`; all m_*valid=0; `m_bready=1`; `m_rready=1`; `rsp_valid=0`; `rsp_data=0`; `rsp_err=0`; `busy=0`.
- **Reset mid-command**: all valids drop immediately (async). The partially issued CSR sequence is abandoned, not completed.
- `cmd_ready = (state==IDLE)`. The command is accepted on `cmd_valid & cmd_ready`, and cmd_op/arg/addr are registered at that edge.
- The first AW/W or AR valid is asserted in the cycle after acceptance.
- Each micro-op completes on the cycle after its B/R handshake. The next micro-op's valid is asserted in that cycle, with no bubble.
- A single-write command (zero-wait slave) reaches `rsp_valid` 3 cycles after acceptance.
- `rsp_valid` is registered. A new command can be accepted in the cycle after the `rsp_ready` handshake.
- cmd_valid while busy is ignored; `cmd_ready=0`.

## Configuration
- `EMU_SEQ_TIMEOUT_EN` defined:
  - A 16-bit poll counter is cleared at the start of each poll micro-op.
  - Once POLL_MAX reads are reached without meeting the condition, abort to RESP with `rsp_err=1` and `rsp_data=0`.
- `EMU_SEQ_TIMEOUT_EN` undefined: polling continues indefinitely and the poll counter logic is absent.

## Test plan
- **STEP**: STEP arg=3, zero-wait slave → writes STEP=3 then STAT=0, in that order; rsp_err=0; rsp_data=0.
- **Skewed handshakes**: HALT with awready delayed 4 cycles and wready delayed 0 → wvalid drops after 1 cycle, awvalid after 5; exactly one B consumed; response follows.
- **SAVE**: SAVE addr=0x0000_0001_2000_0000; DMA_STAT reads bit0=1 three times, then 0; CYCLE_LO=0x1234, CYCLE_HI=0x1 → writes DMA_LO=0x2000_0000, DMA_HI=1, CTRL=1; polls spaced ≥POLL_GAP; rsp_data=0x1_0000_1234.
- **Error and illegal op**: LOAD with bresp=2 on the DMA_LO write → no further CSR writes; rsp_err=1. op=7 → no AW/AR activity; rsp_err=1.
- **Reset mid-SAVE**: rst asserted during the DMA_STAT poll → all valids 0 in the same cycle; busy=0; a subsequent READ_CYCLE completes normally.
- **Timeout (`EMU_SEQ_TIMEOUT_EN`)**: RESET_START with POLL_MAX=4 and STAT bit0 stuck at 0 → exactly 4 STAT reads, then rsp_err=1; the final W STAT=1 is not issued.

Source files
------------

// File: rtl/emu_csr_sequencer.sv
// rtl/emu_csr_sequencer.sv - host command to emulator CSR AXI4-Lite transaction sequencer
// Optional poll timeout: define EMU_SEQ_TIMEOUT_EN.
`ifndef EMU_STAT
`define EMU_STAT 12'h000
`endif
`ifndef EMU_STEP
`define EMU_STEP 12'h004
`endif
`ifndef EMU_CYCLE_LO
`define EMU_CYCLE_LO 12'h010
`endif
`ifndef EMU_CYCLE_HI
`define EMU_CYCLE_HI 12'h014
`endif
`ifndef EMU_DMA_LO
`define EMU_DMA_LO 12'h020
`endif
`ifndef EMU_DMA_HI
`define EMU_DMA_HI 12'h024
`endif
`ifndef EMU_DMA_CTRL
`define EMU_DMA_CTRL 12'h028
`endif
`ifndef EMU_DMA_STAT
`define EMU_DMA_STAT 12'h02C
`endif

module emu_csr_sequencer #(
    parameter logic [11:0] ADDR_STAT     = `EMU_STAT,
    parameter logic [11:0] ADDR_STEP     = `EMU_STEP,
    parameter logic [11:0] ADDR_CYCLE_LO = `EMU_CYCLE_LO,
    parameter logic [11:0] ADDR_CYCLE_HI = `EMU_CYCLE_HI,
    parameter logic [11:0] ADDR_DMA_LO   = `EMU_DMA_LO,
    parameter logic [11:0] ADDR_DMA_HI   = `EMU_DMA_HI,
    parameter logic [11:0] ADDR_DMA_CTRL = `EMU_DMA_CTRL,
    parameter logic [11:0] ADDR_DMA_STAT = `EMU_DMA_STAT,
    parameter int          POLL_GAP      = 16,
    parameter int          POLL_MAX      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [63:0] cmd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [11:0] m_araddr,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [11:0] m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT_B, S_READ, S_WAIT_R, S_DELAY, S_RESP} state_t;
    typedef enum logic [2:0] {K_END, K_WR, K_RD_LO, K_RD_HI, K_POLL_SET, K_POLL_CLR} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [11:0] addr;
        logic [31:0] data;
    } uop_t;

    // Micro-op table: one entry per (command, step); K_END terminates the sequence.
    function automatic uop_t uop(input logic [2:0] op, input logic [3:0] idx,
                                 input logic [31:0] arg, input logic [63:0] base);
        uop_t u;
        u = '{K_END, 12'h000, 32'h0};
        case (op)
            3'd0: if (idx == 4'd0) u = '{K_WR, ADDR_STAT, 32'd0};
            3'd1: if (idx == 4'd0) u = '{K_WR, ADDR_STAT, 32'd1};
            3'd2: case (idx)
                4'd0: u = '{K_WR, ADDR_STEP, arg};
                4'd1: u = '{K_WR, ADDR_STAT, 32'd0};
                default: ;
            endcase
            3'd3: case (idx)
                4'd0: u = '{K_WR, ADDR_STAT, 32'd2};
                4'd1: u = '{K_POLL_SET, ADDR_STAT, 32'd0};
                4'd2: u = '{K_WR, ADDR_STAT, 32'd1};
                default: ;
            endcase
            3'd4: case (idx)
                4'd0: u = '{K_WR, ADDR_STAT, 32'd1};
                4'd1: u = '{K_WR, ADDR_DMA_LO, base[31:0]};
                4'd2: u = '{K_WR, ADDR_DMA_HI, base[63:32]};
                4'd3: u = '{K_WR, ADDR_DMA_CTRL, 32'd1};
                4'd4: u = '{K_POLL_CLR, ADDR_DMA_STAT, 32'd0};
                4'd5: u = '{K_RD_LO, ADDR_CYCLE_LO, 32'd0};
                4'd6: u = '{K_RD_HI, ADDR_CYCLE_HI, 32'd0};
                default: ;
            endcase
            3'd5: case (idx)
                4'd0: u = '{K_WR, ADDR_STAT, 32'd1};
                4'd1: u = '{K_WR, ADDR_CYCLE_LO, arg};
                4'd2: u = '{K_WR, ADDR_DMA_LO, base[31:0]};
                4'd3: u = '{K_WR, ADDR_DMA_HI, base[63:32]};
                4'd4: u = '{K_WR, ADDR_DMA_CTRL, 32'd3};
                4'd5: u = '{K_POLL_CLR, ADDR_DMA_STAT, 32'd0};
                default: ;
            endcase
            3'd6: case (idx)
                4'd0: u = '{K_RD_LO, ADDR_CYCLE_LO, 32'd0};
                4'd1: u = '{K_RD_HI, ADDR_CYCLE_HI, 32'd0};
                default: ;
            endcase
            default: ;
        endcase
        return u;
    endfunction

    function automatic state_t state_for(input kind_t k);
        case (k)
            K_END:   return S_RESP;
            K_WR:    return S_WRITE;
            default: return S_READ;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] arg_q;
    logic [63:0] addr_q;
    logic [3:0]  step;
    logic        aw_done, w_done;
    logic [15:0] gap_cnt;
    uop_t        cur;
    logic        aw_hs, w_hs;
    logic        accept, advance, abort;
    logic        poll_unmet, poll_limit;

    assign cur        = uop(op_q, step, arg_q, addr_q);
    assign aw_hs      = m_awvalid & m_awready;
    assign w_hs       = m_wvalid & m_wready;
    assign poll_unmet = (cur.kind == K_POLL_SET && !m_rdata[0]) ||
                        (cur.kind == K_POLL_CLR &&  m_rdata[0]);

`ifdef EMU_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;
    assign poll_limit = (32'(poll_cnt) + 32'd1) >= 32'(POLL_MAX);
`else
    wire unused_poll_max = (POLL_MAX == 0);
    assign poll_limit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = (cmd_op == 3'd7) ? S_RESP
                          : state_for(uop(cmd_op, 4'd0, cmd_arg, cmd_addr).kind);
            end
            S_WRITE: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WAIT_B;
            S_WAIT_B: if (m_bvalid) begin
                if (m_bresp != 2'b00) begin
                    abort     = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    advance   = 1'b1;
                    state_nxt = state_for(uop(op_q, step + 4'd1, arg_q, addr_q).kind);
                end
            end
            S_READ: if (m_arready) state_nxt = S_WAIT_R;
            S_WAIT_R: if (m_rvalid) begin
                if (m_rresp != 2'b00 || (poll_unmet && poll_limit)) begin
                    abort     = 1'b1;
                    state_nxt = S_RESP;
                end else if (poll_unmet) begin
                    state_nxt = (POLL_GAP == 0) ? S_READ : S_DELAY;
                end else begin
                    advance   = 1'b1;
                    state_nxt = state_for(uop(op_q, step + 4'd1, arg_q, addr_q).kind);
                end
            end
            S_DELAY: if (gap_cnt == 16'(POLL_GAP - 1)) state_nxt = S_READ;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 3'd0;
            arg_q    <= 32'd0;
            addr_q   <= 64'd0;
            step     <= 4'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            gap_cnt  <= 16'd0;
            rsp_data <= 64'd0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                arg_q    <= cmd_arg;
                addr_q   <= cmd_addr;
                step     <= 4'd0;
                rsp_data <= 64'd0;
                rsp_err  <= (cmd_op == 3'd7);
            end
            if (advance) step <= step + 4'd1;
            // AW and W complete independently; both flags clear once the write leaves WRITE.
            if (state != S_WRITE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (state == S_DELAY) gap_cnt <= gap_cnt + 16'd1;
            else                  gap_cnt <= 16'd0;
            if (state == S_WAIT_R && m_rvalid && m_rresp == 2'b00) begin
                if (cur.kind == K_RD_LO) rsp_data[31:0]  <= m_rdata;
                if (cur.kind == K_RD_HI) rsp_data[63:32] <= m_rdata;
            end
            if (abort) begin
                rsp_err  <= 1'b1;
                rsp_data <= 64'd0;
            end
        end
    end

`ifdef EMU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     poll_cnt <= 16'd0;
        else if (accept || advance)  poll_cnt <= 16'd0;
        else if (state == S_WAIT_R && m_rvalid && m_rresp == 2'b00 && poll_unmet)
            poll_cnt <= poll_cnt + 16'd1;
    end
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign m_awvalid = (state == S_WRITE) && !aw_done;
    assign m_wvalid  = (state == S_WRITE) && !w_done;
    assign m_awaddr  = cur.addr;
    assign m_wdata   = cur.data;
    assign m_wstrb   = 4'hF;
    assign m_bready  = 1'b1;
    assign m_arvalid = (state == S_READ);
    assign m_araddr  = cur.addr;
    assign m_rready  = 1'b1;
endmodule
